maze_round_ctrl: RTL and testbench
==================================

// Module: maze_round_ctrl
// PURPOSE
// - Round sequencer above the difficulty selector. Latches the chosen level on start.
// - Handshakes a maze draw with the VGA/draw datapath.
// - Runs a per-level countdown while the player moves, then declares win/lose.
// - Pulses ext_reset to clear the maze datapath before the next round.
// PARAMETERS
// - CLK_HZ     50_000_000  clock cycles per game second (tick divider terminal count)
// - TIME_W     8           width of time_left
// - T_EASY     90          seconds allowed on easy
// - T_MED      60          seconds allowed on medium
// - T_HARD     30          seconds allowed on hard
// PORTS
// - clock          in   1       system clock
// - resetn         in   1       reset, synchronous, active-low
// - start          in   1       1-cycle pulse (debounced key); begins round / acknowledges result
// - hard, med, easy in  1 each  level switches, sampled only in IDLE
// - draw_done      in   1       draw datapath finished maze for draw_level
// - at_exit        in   1       player position equals maze exit (level, sampled in PLAY)
// - draw_req       out  1       held high in DRAW until draw_done seen
// - draw_level     out  2       latched level: 0 none, 1 easy, 2 med, 3 hard
// - play_en        out  1       movement enable to player datapath
// - time_left      out  TIME_W  seconds remaining (registered)
// - win, lose      out  1 each  result flags, held in WIN / LOSE
// - ext_reset      out  1       1-cycle clear pulse to maze/player datapath
// BEHAVIOUR
// - Reset: state IDLE; draw_level=0, time_left=0, tick counter=0; all other outputs 0.
// - Outputs other than time_left/draw_level are Moore-decoded from state.
// - IDLE: on start, exactly one of hard/med/easy set -> latch draw_level -> LOAD.
//   - Zero or multiple switches set: start is ignored, stay IDLE.
// - LOAD (1 cycle): time_left <= T_x for the latched level; tick counter cleared -> DRAW.
// - DRAW: draw_req=1; draw_done=1 -> PLAY next cycle. No timeout.
//   - draw_done outside DRAW is ignored.
// - PLAY: play_en=1; tick counter counts 0..CLK_HZ-1 and wraps; on wrap, time_left decrements.
//   - Transition priority, evaluated each cycle:
//     1. at_exit -> WIN
//     2. switch for draw_level deasserted (abort) -> CLEAR
//     3. wrap with time_left==1, or time_left==0 -> LOSE
//   - At_exit on the same cycle as the final tick -> WIN; time_left ends at 1.
//   - time_left never underflows below 0.
// - WIN / LOSE: flag high, time_left frozen; start -> CLEAR. Other inputs ignored.
// - CLEAR (1 cycle): ext_reset=1, draw_level <= 0 -> IDLE.
// - start pulses outside IDLE/WIN/LOSE are ignored.
// - resetn low in any state overrides everything next edge; no ext_reset pulse on reset.
// CONFIGURATION
// - GAME_PAUSE_EN defined: adds input `pause` (1 bit, level).
//   - In PLAY with pause=1: play_en=0; tick counter and time_left hold; at_exit ignored.
//   - Abort check remains active while paused.
// - GAME_PAUSE_EN undefined: no pause port; PLAY behaves as above with no freeze.
// STRUCTURE
// - maze_game_pkg (shared, `include header): state encodings (IDLE..CLEAR, 3 bits),
//   level codes, default T_EASY/T_MED/T_HARD values.
// - Sub-module game_tick_gen: parameter CLK_HZ; inputs clear, enable; output 1-cycle tick on wrap.
// - FSM, time_left register and level latch stay in maze_round_ctrl.
// TESTING (bench uses CLK_HZ=4, T_EASY=3, T_MED=2, T_HARD=1)
// - easy=1 + start -> LOAD then DRAW; draw_level=1, draw_req=1; draw_done -> play_en next cycle, time_left=3.
// - PLAY easy, no exit -> time_left 3,2,1 every 4 cycles; LOSE on 12th cycle; start -> ext_reset 1 cycle -> IDLE.
// - hard, at_exit on same cycle as final tick -> WIN, time_left=1, lose=0.
// - hard+med+start, and no switch+start -> stay IDLE, all outputs 0.
// - PLAY med, drop med switch -> CLEAR (ext_reset 1 cycle) -> IDLE, draw_level=0.
// - resetn=0 mid-DRAW -> IDLE next edge, draw_req=0, time_left=0.
// - GAME_PAUSE_EN: pause 10 cycles in PLAY -> time_left unchanged, play_en=0; resumes count on release.

Source files
------------

// File: rtl/maze_game_pkg.sv
// Shared encodings for the maze game: round states, level codes and default round lengths.
package maze_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAW  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5,
    ST_CLEAR = 3'd6
  } round_state_e;

  typedef enum logic [1:0] {
    LVL_NONE = 2'd0,
    LVL_EASY = 2'd1,
    LVL_MED  = 2'd2,
    LVL_HARD = 2'd3
  } level_e;

  localparam int unsigned DEF_T_EASY = 90;
  localparam int unsigned DEF_T_MED  = 60;
  localparam int unsigned DEF_T_HARD = 30;

  // One-hot switch set to a level code; anything else maps to LVL_NONE.
  function automatic level_e decode_level(input logic hard, input logic med, input logic easy);
    case ({hard, med, easy})
      3'b100:  return LVL_HARD;
      3'b010:  return LVL_MED;
      3'b001:  return LVL_EASY;
      default: return LVL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/maze_round_ctrl_tick_gen.sv
// Game-second tick divider: counts 0..CLK_HZ-1 while enabled, flags the wrap cycle.
module game_tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = enable && (cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (!resetn)     cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tick_c ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/maze_round_ctrl.sv
// Round sequencer: level latch, draw handshake, countdown and win/lose/clear.
// Optional GAME_PAUSE_EN adds a level-sensitive pause input that freezes play.
module maze_round_ctrl
  import maze_game_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned TIME_W = 8,
  parameter int unsigned T_EASY = DEF_T_EASY,
  parameter int unsigned T_MED  = DEF_T_MED,
  parameter int unsigned T_HARD = DEF_T_HARD
) (
  input  logic              clock,
  input  logic              resetn,
`ifdef GAME_PAUSE_EN
  input  logic              pause,
`endif
  input  logic              start,
  input  logic              hard,
  input  logic              med,
  input  logic              easy,
  input  logic              draw_done,
  input  logic              at_exit,
  output logic              draw_req,
  output logic [1:0]        draw_level,
  output logic              play_en,
  output logic [TIME_W-1:0] time_left,
  output logic              win,
  output logic              lose,
  output logic              ext_reset
);

  round_state_e      state, state_nxt;
  logic [1:0]        level_nxt;
  logic [TIME_W-1:0] time_nxt;
  logic [TIME_W-1:0] lvl_time_c;
  logic              lvl_sw_c;
  logic              paused_c;
  logic              tick_c;
  level_e            sel_lvl_c;

`ifdef GAME_PAUSE_EN
  assign paused_c = pause;
`else
  assign paused_c = 1'b0;
`endif

  assign sel_lvl_c = decode_level(hard, med, easy);

  game_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .clear  (state == ST_LOAD),
    .enable ((state == ST_PLAY) && !paused_c),
    .tick_c (tick_c)
  );

  // Round length and still-selected switch for the latched level.
  always_comb begin
    lvl_time_c = '0;
    lvl_sw_c   = 1'b0;
    case (draw_level)
      LVL_EASY: begin lvl_time_c = TIME_W'(T_EASY); lvl_sw_c = easy; end
      LVL_MED:  begin lvl_time_c = TIME_W'(T_MED);  lvl_sw_c = med;  end
      LVL_HARD: begin lvl_time_c = TIME_W'(T_HARD); lvl_sw_c = hard; end
      default:  begin lvl_time_c = '0;              lvl_sw_c = 1'b0; end
    endcase
  end

  always_comb begin
    state_nxt = state;
    level_nxt = draw_level;
    time_nxt  = time_left;
    case (state)
      ST_IDLE: begin
        if (start && (sel_lvl_c != LVL_NONE)) begin
          level_nxt = sel_lvl_c;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        time_nxt  = lvl_time_c;
        state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        if (draw_done) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        // Exit beats abort beats timeout; a winning final tick leaves time_left untouched.
        if (!paused_c && at_exit) begin
          state_nxt = ST_WIN;
        end else if (!lvl_sw_c) begin
          state_nxt = ST_CLEAR;
        end else if (!paused_c) begin
          if (tick_c && (time_left != '0)) time_nxt = time_left - TIME_W'(1);
          if ((tick_c && (time_left == TIME_W'(1))) || (time_left == '0))
            state_nxt = ST_LOSE;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        level_nxt = LVL_NONE;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs registered from the next state so they track the state register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      draw_level <= '0;
      time_left  <= '0;
      draw_req   <= 1'b0;
      play_en    <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
      ext_reset  <= 1'b0;
    end else begin
      state      <= state_nxt;
      draw_level <= level_nxt;
      time_left  <= time_nxt;
      draw_req   <= (state_nxt == ST_DRAW);
      play_en    <= (state_nxt == ST_PLAY) && !paused_c;
      win        <= (state_nxt == ST_WIN);
      lose       <= (state_nxt == ST_LOSE);
      ext_reset  <= (state_nxt == ST_CLEAR);
    end
  end

endmodule

// File: tb/tb_maze_round_ctrl.sv
// Directed bench for maze_round_ctrl with a 4-cycle game second and 3/2/1 second levels.
module tb_maze_round_ctrl;

  localparam int unsigned TIME_W = 8;

  logic              clock = 1'b0;
  logic              resetn;
  logic              pause;
  logic              start, hard, med, easy, draw_done, at_exit;
  logic              draw_req, play_en, win, lose, ext_reset;
  logic [1:0]        draw_level;
  logic [TIME_W-1:0] time_left;

  int n_checks = 0;
  int n_pass   = 0;

  maze_round_ctrl #(
    .CLK_HZ(4), .TIME_W(TIME_W), .T_EASY(3), .T_MED(2), .T_HARD(1)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
`ifdef GAME_PAUSE_EN
    .pause      (pause),
`endif
    .start      (start),
    .hard       (hard),
    .med        (med),
    .easy       (easy),
    .draw_done  (draw_done),
    .at_exit    (at_exit),
    .draw_req   (draw_req),
    .draw_level (draw_level),
    .play_en    (play_en),
    .time_left  (time_left),
    .win        (win),
    .lose       (lose),
    .ext_reset  (ext_reset)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance n edges; inputs set afterwards are seen at the following edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".draw_req"},   int'(draw_req),   0);
    check({tag, ".draw_level"}, int'(draw_level), 0);
    check({tag, ".play_en"},    int'(play_en),    0);
    check({tag, ".time_left"},  int'(time_left),  0);
    check({tag, ".win"},        int'(win),        0);
    check({tag, ".lose"},       int'(lose),       0);
    check({tag, ".ext_reset"},  int'(ext_reset),  0);
  endtask

  // Start a round with the given switches and bring it into PLAY.
  task automatic enter_play(input logic h, input logic m, input logic e);
    {hard, med, easy} = {h, m, e};
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    draw_done = 1'b1;
    cyc(1);
    draw_done = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; pause = 1'b0; start = 1'b0;
    hard = 1'b0; med = 1'b0; easy = 1'b0; draw_done = 1'b0; at_exit = 1'b0;
    cyc(2);
    check_quiet("reset");
    resetn = 1'b1;
    cyc(1);

    // Invalid selections are ignored.
    hard = 1'b1; med = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    check_quiet("multi_sel");
    hard = 1'b0; med = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    check_quiet("no_sel");

    // Easy round: handshake then timeout.
    easy = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("easy_load.draw_level", int'(draw_level), 1);
    check("easy_load.draw_req",   int'(draw_req),   0);
    cyc(1);
    check("easy_draw.draw_req",  int'(draw_req),  1);
    check("easy_draw.time_left", int'(time_left), 3);
    check("easy_draw.play_en",   int'(play_en),   0);
    cyc(2);
    check("easy_wait.draw_req", int'(draw_req), 1);
    draw_done = 1'b1;
    cyc(1);
    draw_done = 1'b0;
    check("easy_play.play_en",   int'(play_en),   1);
    check("easy_play.draw_req",  int'(draw_req),  0);
    check("easy_play.time_left", int'(time_left), 3);
    cyc(3);
    check("easy_e3.time_left", int'(time_left), 3);
    cyc(1);
    check("easy_e4.time_left", int'(time_left), 2);
    cyc(4);
    check("easy_e8.time_left", int'(time_left), 1);
    start = 1'b1;
    cyc(3);
    start = 1'b0;
    check("easy_e11.lose",    int'(lose),    0);
    check("easy_e11.play_en", int'(play_en), 1);
    cyc(1);
    check("easy_e12.lose",    int'(lose),    1);
    check("easy_e12.play_en", int'(play_en), 0);
    cyc(2);
    check("easy_lose_hold", int'(lose), 1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("easy_clear.ext_reset", int'(ext_reset), 1);
    check("easy_clear.lose",      int'(lose),      0);
    cyc(1);
    check("easy_idle.ext_reset",  int'(ext_reset),  0);
    check("easy_idle.draw_level", int'(draw_level), 0);
    easy = 1'b0;

    // Hard round: exit on the final tick wins with one second left.
    enter_play(1'b1, 1'b0, 1'b0);
    check("hard_play.time_left",  int'(time_left),  1);
    check("hard_play.draw_level", int'(draw_level), 3);
    cyc(3);
    at_exit = 1'b1;
    cyc(1);
    at_exit = 1'b0;
    check("hard_win.win",       int'(win),       1);
    check("hard_win.lose",      int'(lose),      0);
    check("hard_win.time_left", int'(time_left), 1);
    cyc(2);
    check("hard_win_hold", int'(win), 1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("hard_clear.ext_reset", int'(ext_reset), 1);
    cyc(1);
    check("hard_idle.win", int'(win), 0);
    hard = 1'b0;

    // Medium round aborted by dropping the switch.
    enter_play(1'b0, 1'b1, 1'b0);
    check("med_play.time_left", int'(time_left), 2);
    cyc(2);
    med = 1'b0;
    cyc(1);
    check("med_abort.ext_reset", int'(ext_reset), 1);
    check("med_abort.play_en",   int'(play_en),   0);
    cyc(1);
    check("med_idle.ext_reset",  int'(ext_reset),  0);
    check("med_idle.draw_level", int'(draw_level), 0);

    // Reset in the middle of DRAW.
    easy = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    check("rst_draw.draw_req", int'(draw_req), 1);
    resetn = 1'b0;
    cyc(1);
    check_quiet("rst_mid");
    resetn = 1'b1;

`ifdef GAME_PAUSE_EN
    // Pause freezes countdown and ignores the exit.
    enter_play(1'b0, 1'b0, 1'b1);
    cyc(2);
    pause = 1'b1;
    cyc(1);
    check("pause.play_en", int'(play_en), 0);
    at_exit = 1'b1;
    cyc(9);
    at_exit = 1'b0;
    check("pause.time_left", int'(time_left), 3);
    check("pause.win",       int'(win),       0);
    pause = 1'b0;
    cyc(1);
    check("resume.play_en",   int'(play_en),   1);
    check("resume.time_left", int'(time_left), 3);
    cyc(1);
    check("resume_tick.time_left", int'(time_left), 2);
    easy = 1'b0;
    cyc(2);
`endif
    easy = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
